// File: rtl/ifetch_resp.sv
// ---------------------------------------------------------------------------
// ifetch_resp
//   Instruction-side responder between the PC stage and the IF/ID boundary.
//   Runs one request/ack transaction on the instruction bus per fetch. It
//   presents the fetched word with a valid flag and freezes the PC stage
//   (fetch_stall) while a fetch is outstanding. A word that completes during a
//   downstream stall is parked in a one-entry buffer (HOLD). A flush kills
//   whatever is in flight or parked. Misaligned fetch addresses and bus
//   timeouts are reported as flagged NOP slots.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   stall              downstream stall (ID and later)
//   flush              pipeline flush, highest priority
//   iram_en, pc        fetch request and address from the PC stage
//   ibus_req/addr      bus request (held until ack) and its address
//   ibus_ack/rdata     bus completion and read data (same cycle)
//   fetch_stall        combinational freeze request to the PC stage
//   inst, inst_pc      registered instruction and its address
//   inst_valid         slot holds a live instruction
//   inst_adel          slot is an address-error NOP
//   inst_buserr        slot is a bus-timeout NOP
// ---------------------------------------------------------------------------
module ifetch_resp #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] NOP     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        iram_en,
    input  logic [31:0] pc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        fetch_stall,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        inst_adel,
    output logic        inst_buserr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   buf_q, buf_d;
    logic          kill_q, kill_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   inst_q, inst_d;
    logic [31:0]   inst_pc_q, inst_pc_d;
    logic          valid_q, valid_d;
    logic          adel_q, adel_d;
    logic          buserr_q, buserr_d;

    // Output-register load request produced by the state logic.
    logic          load;
    logic [31:0]   ld_inst;
    logic [31:0]   ld_pc;
    logic          ld_adel;
    logic          ld_buserr;

    logic          accept;
    logic          aligned;

    assign accept  = iram_en & ~flush & ~stall;
    assign aligned = (pc[1:0] == 2'b00);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        kill_d      = kill_q;
        cnt_d       = cnt_q;
        ibus_req    = 1'b0;
        ibus_addr   = addr_q;
        fetch_stall = 1'b0;
        load        = 1'b0;
        ld_inst     = NOP;
        ld_pc       = addr_q;
        ld_adel     = 1'b0;
        ld_buserr   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (aligned) begin
                        ibus_req  = 1'b1;
                        ibus_addr = pc;
                        if (ibus_ack) begin
                            load    = 1'b1;
                            ld_inst = ibus_rdata;
                            ld_pc   = pc;
                        end else begin
                            addr_d      = pc;
                            cnt_d       = '0;
                            state_d     = S_WAIT;
                            fetch_stall = 1'b1;
                        end
                    end else begin
                        load    = 1'b1;
                        ld_pc   = pc;
                        ld_adel = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                ibus_req    = 1'b1;
                ibus_addr   = addr_q;
                fetch_stall = kill_q | ~ibus_ack;
                cnt_d       = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
                if (ibus_ack) begin
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (!stall) begin
                        load    = 1'b1;
                        ld_inst = ibus_rdata;
                        ld_pc   = addr_q;
                        state_d = S_IDLE;
                    end else begin
                        buf_d   = ibus_rdata;
                        state_d = S_HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (!stall) begin
                        load      = 1'b1;
                        ld_pc     = addr_q;
                        ld_buserr = 1'b1;
                        state_d   = S_IDLE;
                    end
                    // A live timeout under stall waits here (counter saturated)
                    // so the error slot cannot overwrite an instruction that ID
                    // has not yet taken.
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    load    = 1'b1;
                    ld_inst = buf_q;
                    ld_pc   = addr_q;
                    state_d = S_IDLE;
                    if (accept) begin
                        if (aligned) begin
                            ibus_req  = 1'b1;
                            ibus_addr = pc;
                            addr_d    = pc;
                            if (ibus_ack) begin
                                // Output reg is busy with the parked word this
                                // cycle, so park the new one and drain it next.
                                buf_d   = ibus_rdata;
                                state_d = S_HOLD;
                            end else begin
                                cnt_d       = '0;
                                state_d     = S_WAIT;
                                fetch_stall = 1'b1;
                            end
                        end else begin
                            // The adel slot also needs the output reg; freeze
                            // the PC for one cycle and accept it from IDLE.
                            fetch_stall = 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Output register: flush clears, a load wins next, stall holds, and an
    // unstalled cycle without a load empties the slot.
    always_comb begin
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        adel_d    = adel_q;
        buserr_d  = buserr_q;
        if (flush) begin
            inst_d   = NOP;
            valid_d  = 1'b0;
            adel_d   = 1'b0;
            buserr_d = 1'b0;
        end else if (load) begin
            inst_d    = ld_inst;
            inst_pc_d = ld_pc;
            valid_d   = 1'b1;
            adel_d    = ld_adel;
            buserr_d  = ld_buserr;
        end else if (!stall) begin
            inst_d   = NOP;
            valid_d  = 1'b0;
            adel_d   = 1'b0;
            buserr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            buf_q     <= NOP;
            kill_q    <= 1'b0;
            cnt_q     <= '0;
            inst_q    <= NOP;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            adel_q    <= 1'b0;
            buserr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            buf_q     <= buf_d;
            kill_q    <= kill_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            adel_q    <= adel_d;
            buserr_q  <= buserr_d;
        end
    end

    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = valid_q;
    assign inst_adel   = adel_q;
    assign inst_buserr = buserr_q;

endmodule

// File: tb/tb_ifetch_resp.sv
// ---------------------------------------------------------------------------
// tb_ifetch_resp
//   Directed scenarios for ifetch_resp (built with TIMEOUT=4). Expected
//   instruction slots are queued when the completing bus cycle is driven and
//   popped by a monitor whenever ID would consume a valid slot. Bus-side and
//   stall behaviour is checked directly inside each scenario.
// ---------------------------------------------------------------------------
module tb_ifetch_resp;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        iram_en;
    logic [31:0] pc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic        fetch_stall;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_adel;
    logic        inst_buserr;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
        logic        buserr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp;
    int n_bad;

    ifetch_resp #(
        .TIMEOUT (4),
        .NOP     (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .iram_en     (iram_en),
        .pc          (pc),
        .ibus_req    (ibus_req),
        .ibus_addr   (ibus_addr),
        .ibus_ack    (ibus_ack),
        .ibus_rdata  (ibus_rdata),
        .fetch_stall (fetch_stall),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_adel   (inst_adel),
        .inst_buserr (inst_buserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic a, input logic b);
        exp_t e;
        e.inst   = i;
        e.pc     = p;
        e.adel   = a;
        e.buserr = b;
        sb.push_back(e);
    endtask

    // ID consumes a valid slot on any cycle it is neither stalled nor flushed.
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall && !flush) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 32'(inst_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("txn pc=%h inst=%h adel=%0d buserr=%0d", inst_pc, inst, inst_adel, inst_buserr);
                chk("sb_inst", inst, mon_e.inst);
                chk("sb_pc", inst_pc, mon_e.pc);
                chk("sb_flags", {30'b0, inst_adel, inst_buserr}, {30'b0, mon_e.adel, mon_e.buserr});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        iram_en    = 1'b0;
        pc         = '0;
        ibus_ack   = 1'b0;
        ibus_rdata = '0;

        // Reset state
        tick();
        tick();
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req", 32'(ibus_req), 32'd0);
        chk("rst_fstall", 32'(fetch_stall), 32'd0);

        // 1. Zero-wait fetch
        tick();
        rst        = 1'b0;
        iram_en    = 1'b1;
        pc         = 32'hBFC0_0000;
        ibus_ack   = 1'b1;
        ibus_rdata = 32'h3C1D_0001;
        #1;
        chk("t1_req", 32'(ibus_req), 32'd1);
        chk("t1_addr", ibus_addr, 32'hBFC0_0000);
        chk("t1_fstall", 32'(fetch_stall), 32'd0);
        push(32'h3C1D_0001, 32'hBFC0_0000, 1'b0, 1'b0);
        tick();
        iram_en  = 1'b0;
        ibus_ack = 1'b0;
        #1;
        chk("t1_inst", inst, 32'h3C1D_0001);
        chk("t1_inst_pc", inst_pc, 32'hBFC0_0000);
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_fstall2", 32'(fetch_stall), 32'd0);
        tick();
        chk("t1_valid_drop", 32'(inst_valid), 32'd0);

        // 2. Ack on the third wait cycle
        iram_en = 1'b1;
        pc      = 32'h8000_0010;
        #1;
        chk("t2_fstall_a", 32'(fetch_stall), 32'd1);
        chk("t2_addr_a", ibus_addr, 32'h8000_0010);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t2_fstall_w", 32'(fetch_stall), 32'd1);
            chk("t2_req_w", 32'(ibus_req), 32'd1);
            chk("t2_addr_w", ibus_addr, 32'h8000_0010);
        end
        tick();
        ibus_ack   = 1'b1;
        ibus_rdata = 32'h2408_0005;
        #1;
        chk("t2_fstall_ack", 32'(fetch_stall), 32'd0);
        push(32'h2408_0005, 32'h8000_0010, 1'b0, 1'b0);
        tick();
        ibus_ack = 1'b0;
        iram_en  = 1'b0;
        #1;
        chk("t2_valid", 32'(inst_valid), 32'd1);
        chk("t2_inst", inst, 32'h2408_0005);

        // 3. Ack under stall, parked in HOLD, released two cycles later
        tick();
        iram_en = 1'b1;
        pc      = 32'h8000_000C;
        #1;
        chk("t3_fstall_a", 32'(fetch_stall), 32'd1);
        tick();
        stall      = 1'b1;
        ibus_ack   = 1'b1;
        ibus_rdata = 32'h8C02_0000;
        #1;
        chk("t3_fstall_ack", 32'(fetch_stall), 32'd0);
        push(32'h8C02_0000, 32'h8000_000C, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            ibus_ack = 1'b0;
            pc       = 32'h8000_0014;
            #1;
            chk("t3_hold_req", 32'(ibus_req), 32'd0);
            chk("t3_hold_fstall", 32'(fetch_stall), 32'd0);
            chk("t3_hold_valid", 32'(inst_valid), 32'd0);
        end
        tick();
        stall = 1'b0;
        #1;
        chk("t3_rel_req", 32'(ibus_req), 32'd1);
        chk("t3_rel_addr", ibus_addr, 32'h8000_0014);
        chk("t3_rel_fstall", 32'(fetch_stall), 32'd1);
        tick();
        ibus_ack   = 1'b1;
        ibus_rdata = 32'hAC03_0004;
        #1;
        chk("t3_buf_inst", inst, 32'h8C02_0000);
        chk("t3_buf_pc", inst_pc, 32'h8000_000C);
        chk("t3_buf_valid", 32'(inst_valid), 32'd1);
        push(32'hAC03_0004, 32'h8000_0014, 1'b0, 1'b0);
        tick();
        ibus_ack = 1'b0;
        iram_en  = 1'b0;
        #1;
        chk("t3_new_inst", inst, 32'hAC03_0004);

        // 4. Flush one cycle after the request; ack arrives two cycles later
        tick();
        iram_en = 1'b1;
        pc      = 32'h8000_0020;
        #1;
        chk("t4_req", 32'(ibus_req), 32'd1);
        tick();
        flush = 1'b1;
        #1;
        chk("t4_fstall_f", 32'(fetch_stall), 32'd1);
        tick();
        flush = 1'b0;
        #1;
        chk("t4_fstall_k", 32'(fetch_stall), 32'd1);
        chk("t4_valid_k", 32'(inst_valid), 32'd0);
        tick();
        ibus_ack   = 1'b1;
        ibus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t4_fstall_ack", 32'(fetch_stall), 32'd1);
        chk("t4_valid_ack", 32'(inst_valid), 32'd0);
        tick();
        ibus_ack = 1'b0;
        iram_en  = 1'b0;
        #1;
        chk("t4_valid_after", 32'(inst_valid), 32'd0);
        chk("t4_req_after", 32'(ibus_req), 32'd0);

        // 5. Misaligned fetch address
        tick();
        iram_en = 1'b1;
        pc      = 32'h8000_0002;
        #1;
        chk("t5_req", 32'(ibus_req), 32'd0);
        chk("t5_fstall", 32'(fetch_stall), 32'd0);
        push(32'h0, 32'h8000_0002, 1'b1, 1'b0);
        tick();
        iram_en = 1'b0;
        #1;
        chk("t5_inst", inst, 32'h0);
        chk("t5_valid", 32'(inst_valid), 32'd1);
        chk("t5_adel", 32'(inst_adel), 32'd1);

        // 6. Bus timeout (TIMEOUT=4), then reset in the middle of a wait
        tick();
        iram_en = 1'b1;
        pc      = 32'h8000_0030;
        #1;
        chk("t6_req_a", 32'(ibus_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_req_w", 32'(ibus_req), 32'd1);
            chk("t6_fstall_w", 32'(fetch_stall), 32'd1);
            if (i == 3) push(32'h0, 32'h8000_0030, 1'b0, 1'b1);
        end
        tick();
        iram_en = 1'b0;
        #1;
        chk("t6_req_drop", 32'(ibus_req), 32'd0);
        chk("t6_buserr", 32'(inst_buserr), 32'd1);
        chk("t6_valid", 32'(inst_valid), 32'd1);
        chk("t6_inst_pc", inst_pc, 32'h8000_0030);
        tick();
        iram_en = 1'b1;
        pc      = 32'h8000_0040;
        tick();
        #1;
        chk("t6_req_w2", 32'(ibus_req), 32'd1);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        iram_en = 1'b0;
        #1;
        chk("t6_rst_req", 32'(ibus_req), 32'd0);
        chk("t6_rst_fstall", 32'(fetch_stall), 32'd0);
        chk("t6_rst_valid", 32'(inst_valid), 32'd0);
        chk("t6_rst_inst_pc", inst_pc, 32'h0);
        chk("t6_rst_buserr", 32'(inst_buserr), 32'd0);
        tick();
        ibus_ack = 1'b1;
        #1;
        chk("t6_stray_req", 32'(ibus_req), 32'd0);
        tick();
        ibus_ack = 1'b0;
        #1;
        chk("t6_stray_valid", 32'(inst_valid), 32'd0);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
